// File: rtl/bcd_updown_counter_n.sv
// Cascaded BCD up/down counter with a wrap/saturate mode register, validated
// parallel load, and one-cycle event pulses. Every digit has its own step slice.

module bcd_digit_step (
   input  logic [3:0] d,
   input  logic       cin,
   input  logic       dn,
   output logic [3:0] q
);
   always_comb begin
      q = d;
      if (cin) begin
         if (!dn) q = (d >= 4'd9) ? 4'd0 : d + 4'd1;
         else     q = (d == 4'd0) ? 4'd9 : d - 4'd1;
      end
   end
endmodule

module bcd_updown_counter_n #(
   parameter int DIGITS      = 4,
   parameter bit SAT_DEFAULT = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  mode_wr,
   input  logic                  sat_in,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic                  sat_hit,
   output logic                  load_err,
   output logic                  at_max,
   output logic                  at_zero
);
   logic [DIGITS-1:0][3:0] cnt_q;
   logic [DIGITS-1:0][3:0] step_val;
   logic [DIGITS-1:0]      cin;
   logic                   carry_out;
   logic                   mode_q;
   logic                   load_ok;
   logic                   step_up;
   logic                   step_dn;

   assign step_up = en & up & ~down;
   assign step_dn = en & down & ~up;
   assign count   = cnt_q;

   // Carry into digit k is computed directly from the lower digits so the
   // chain stays a single combinational block with no feedback through slices.
   always_comb begin
      logic run;
      logic all9;
      logic all0;
      logic ok;
      run  = 1'b1;
      all9 = 1'b1;
      all0 = 1'b1;
      ok   = 1'b1;
      cin  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         cin[k] = run;
         run    = run & (step_dn ? (cnt_q[k] == 4'd0) : (cnt_q[k] == 4'd9));
         all9   = all9 & (cnt_q[k] == 4'd9);
         all0   = all0 & (cnt_q[k] == 4'd0);
         ok     = ok & (load_val[4*k +: 4] <= 4'd9);
      end
      carry_out = run;
      at_max    = all9;
      at_zero   = all0;
      load_ok   = ok;
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_digit_step u_dig (
         .d   (cnt_q[k]),
         .cin (cin[k]),
         .dn  (step_dn),
         .q   (step_val[k])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         wrap     <= 1'b0;
         sat_hit  <= 1'b0;
         load_err <= 1'b0;
         mode_q   <= SAT_DEFAULT;
      end else begin
         wrap     <= 1'b0;
         sat_hit  <= 1'b0;
         load_err <= 1'b0;
         if (mode_wr) mode_q <= sat_in;
         if (load) begin
            if (load_ok) cnt_q    <= load_val;
            else         load_err <= 1'b1;
         end else if (step_up || step_dn) begin
            // carry_out means the whole counter sits at the limit being crossed
            if (carry_out && mode_q) begin
               sat_hit <= 1'b1;
            end else begin
               cnt_q <= step_val;
               wrap  <= carry_out;
            end
         end
      end
   end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench: a 2-digit and a 4-digit counter driven from one sequence.

module tb_bcd_updown_counter_n;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        en2, up2, dn2, ld2, mw2, si2;
   logic [7:0]  lv2;
   logic [7:0]  cnt2;
   logic        wr2, sh2, le2, mx2, z2;
   logic        en4, up4, dn4, ld4, mw4, si4;
   logic [15:0] lv4;
   logic [15:0] cnt4;
   logic        wr4, sh4, le4, mx4, z4;
   int          n_asrt = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   bcd_updown_counter_n #(.DIGITS(2), .SAT_DEFAULT(1'b0)) u2 (
      .clk(clk), .reset(rst_n), .en(en2), .up(up2), .down(dn2), .load(ld2),
      .load_val(lv2), .mode_wr(mw2), .sat_in(si2), .count(cnt2), .wrap(wr2),
      .sat_hit(sh2), .load_err(le2), .at_max(mx2), .at_zero(z2));

   bcd_updown_counter_n #(.DIGITS(4), .SAT_DEFAULT(1'b0)) u4 (
      .clk(clk), .reset(rst_n), .en(en4), .up(up4), .down(dn4), .load(ld4),
      .load_val(lv4), .mode_wr(mw4), .sat_in(si4), .count(cnt4), .wrap(wr4),
      .sat_hit(sh4), .load_err(le4), .at_max(mx4), .at_zero(z4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] bcd2(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   initial begin
      rst_n = 1'b0;
      {en2, up2, dn2, ld2, mw2, si2} = '0; lv2 = '0;
      {en4, up4, dn4, ld4, mw4, si4} = '0; lv4 = '0;
      #3;
      chk("rst_cnt2", cnt2, 0);
      chk("rst_cnt4", cnt4, 0);
      chk("rst_flags2", {wr2, sh2, le2, mx2, z2}, 5'b00001);
      chk("rst_flags4", {wr4, sh4, le4, mx4, z4}, 5'b00001);
      @(negedge clk);
      rst_n = 1'b1;

      // 00..99 then 00, single wrap pulse
      en2 = 1'b1; up2 = 1'b1;
      for (int i = 1; i <= 101; i++) begin
         tick();
         chk("run_cnt", cnt2, bcd2(i % 100));
         chk("run_wrap", wr2, (i == 100));
      end
      en2 = 1'b0; up2 = 1'b0;
      tick();
      chk("idle_wrap", wr2, 0);

      // load then borrow across digits, then up+down hold
      ld2 = 1'b1; lv2 = 8'h10;
      tick(); chk("ld10", cnt2, 8'h10);
      ld2 = 1'b0; en2 = 1'b1; dn2 = 1'b1;
      tick(); chk("dn09", cnt2, 8'h09);
      tick(); chk("dn08", cnt2, 8'h08);
      up2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("both_hold", cnt2, 8'h08);
         chk("both_pulses", {wr2, sh2, le2}, 3'b000);
      end
      up2 = 1'b0; dn2 = 1'b0;

      // invalid load rejected, then valid load wins over up
      en2 = 1'b0; ld2 = 1'b1; lv2 = 8'h3A;
      tick(); chk("bad_ld_cnt", cnt2, 8'h08); chk("bad_ld_err", le2, 1);
      lv2 = 8'h42; en2 = 1'b1; up2 = 1'b1;
      tick(); chk("ld42", cnt2, 8'h42); chk("ld42_err", le2, 0);

      // saturate mode written alongside a load
      up2 = 1'b0; lv2 = 8'h98; mw2 = 1'b1; si2 = 1'b1;
      tick(); chk("ld98", cnt2, 8'h98);
      ld2 = 1'b0; mw2 = 1'b0; si2 = 1'b0; up2 = 1'b1;
      tick(); chk("sat99a", cnt2, 8'h99); chk("sat_a", sh2, 0); chk("max_a", mx2, 1);
      tick(); chk("sat99b", cnt2, 8'h99); chk("sat_b", sh2, 1); chk("wrap_b", wr2, 0);
      tick(); chk("sat99c", cnt2, 8'h99); chk("sat_c", sh2, 1); chk("wrap_c", wr2, 0);
      up2 = 1'b0;
      tick(); chk("sat_clr", sh2, 0); chk("max_hold", mx2, 1);
      ld2 = 1'b1; lv2 = 8'h00;
      tick(); chk("ld00", cnt2, 0);
      ld2 = 1'b0; dn2 = 1'b1;
      tick(); chk("satdn_cnt", cnt2, 0); chk("satdn_hit", sh2, 1); chk("satdn_zero", z2, 1);
      dn2 = 1'b0; en2 = 1'b0;

      // 4 digits, wrap mode: 0000 down -> 9999
      en4 = 1'b1; dn4 = 1'b1;
      tick(); chk("w4_cnt", cnt4, 16'h9999); chk("w4_wrap", wr4, 1); chk("w4_max", mx4, 1);
      dn4 = 1'b0; en4 = 1'b0; up4 = 1'b1;
      tick(); chk("w4_hold", cnt4, 16'h9999); chk("w4_hold_wrap", wr4, 0);
      en4 = 1'b1;
      tick(); chk("w4_up", cnt4, 16'h0000); chk("w4_up_wrap", wr4, 1);
      up4 = 1'b0; ld4 = 1'b1; lv4 = 16'h0999;
      tick(); chk("ld0999", cnt4, 16'h0999);
      ld4 = 1'b0; up4 = 1'b1;
      tick(); chk("c4_1000", cnt4, 16'h1000); chk("c4_wrap", wr4, 0);
      up4 = 1'b0; dn4 = 1'b1;
      tick(); chk("b4_0999", cnt4, 16'h0999);
      dn4 = 1'b0; ld4 = 1'b1; lv4 = 16'h12F4;
      tick(); chk("bad4_cnt", cnt4, 16'h0999); chk("bad4_err", le4, 1);

      // async reset mid-count
      lv4 = 16'h1234;
      tick(); chk("ld1234", cnt4, 16'h1234);
      ld4 = 1'b0; up4 = 1'b1;
      tick(); chk("up1235", cnt4, 16'h1235);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cnt4", cnt4, 0);
      chk("arst_z4", z4, 1);
      ld4 = 1'b1; lv4 = 16'h5555;
      @(posedge clk); #2;
      chk("arst_hold", cnt4, 0);
      ld4 = 1'b0;
      rst_n = 1'b1;
      tick(); chk("post_rst", cnt4, 16'h0001);
      // mode register back to wrap after reset
      up4 = 1'b0; en4 = 1'b0;
      en2 = 1'b1; dn2 = 1'b1;
      tick(); chk("mode_rst_cnt", cnt2, 8'h99); chk("mode_rst_wrap", wr2, 1);
      en2 = 1'b0; dn2 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
